sram_mem_controller: RTL and testbench



---
 rtl/arm_mem_pkg.sv | 23 ++
 rtl/sram_phase_counter.sv | 39 +++
 rtl/sram_mem_controller.sv | 137 +++++++++++++
 tb/tb_sram_mem_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory path to the board SRAM.
package arm_mem_pkg;

  localparam int unsigned SRAM_AW        = 18;
  localparam int unsigned SRAM_DW        = 16;
  localparam int unsigned DATA_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } mem_state_e;

  // 32-bit word index inside the SRAM window; offsets wrap modulo the SRAM size.
  function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return offset[SRAM_AW:2];
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Modulo-WAIT_CYCLES counter that times one 16-bit SRAM access phase.
module sram_phase_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o,
  output logic we_window_o
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  logic [CntW-1:0] count_q, count_d;

  assign last_o = (count_q == CntW'(WAIT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  // Evaluated on the upcoming count so the strobe can be registered without a cycle of lag.
  assign we_window_o = (32'(count_d) < WAIT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory responder: serves each 32-bit access as two 16-bit async SRAM phases.
module sram_mem_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned BASE_ADDR   = DATA_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_we_n
);

  mem_state_e         state_q, state_d;
  logic               is_write_q, is_write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [SRAM_AW-2:0] idx_q, idx_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               last, we_window, in_phase;

  assign in_phase = (state_q == StLow) || (state_q == StHigh);

  sram_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_counter (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (!in_phase),
    .en_i        (in_phase),
    .last_o      (last),
    .we_window_o (we_window)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    read_data_d = read_data_q;
    unique case (state_q)
      StIdle: begin
        if (wr_en || rd_en) begin
          state_d    = StLow;
          is_write_d = wr_en;
          wdata_d    = write_data;
          idx_d      = word_index(address, 32'(BASE_ADDR));
        end
      end
      StLow: begin
        if (last) begin
          state_d = StHigh;
          if (!is_write_q) read_data_d[15:0] = sram_dq_in;
        end
      end
      StHigh: begin
        if (last) begin
          state_d = StDone;
          if (!is_write_q) read_data_d[31:16] = sram_dq_in;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values are derived from next state so the registered pins line up with the phase.
  always_comb begin
    sram_addr_d = '0;
    dq_out_d    = '0;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    unique case (state_d)
      StLow: begin
        sram_addr_d = {idx_d, 1'b0};
        if (is_write_d) begin
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_d[15:0];
          we_n_d   = !we_window;
        end
      end
      StHigh: begin
        sram_addr_d = {idx_d, 1'b1};
        if (is_write_d) begin
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_d[31:16];
          we_n_d   = !we_window;
        end
      end
      default: ;
    endcase
  end

  assign ready       = (state_q == StDone) || ((state_q == StIdle) && !(wr_en || rd_en));
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a behavioural 256Kx16 async SRAM.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:262143];
  logic        we_n_prev = 1'b1;

  // Per-cycle record of one transaction, bit/element i = cycle i after the request appears.
  logic [5:0]  rdy_v, wen_v, oe_v;
  logic [17:0] addr_r [6];
  logic [31:0] rd_r   [6];

  sram_mem_controller #(
    .WAIT_CYCLES (2),
    .BASE_ADDR   (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM commits on the rising edge of we_n, only if the controller still drives the bus.
  assign sram_dq_in = mem[sram_addr];
  always @(negedge clk) begin
    if (!we_n_prev && sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
    we_n_prev = sram_we_n;
  end

  task automatic run_req(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input bit drop);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy_v[i]  = ready;
      wen_v[i]  = sram_we_n;
      oe_v[i]   = sram_dq_oe;
      addr_r[i] = sram_addr;
      rd_r[i]   = read_data;
      @(posedge clk); #1;
      if (drop && i == 0) begin
        wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", read_data); end
    total++; if (sram_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
    total++; if (sram_dq_out !== 16'h0) begin bad++; $display("FAIL reset_dq got=%h want=0", sram_dq_out); end
    total++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", sram_dq_oe); end
    total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n got=%b want=1", sram_we_n); end
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    run_req(1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1'b0);
    total++; if (rdy_v !== 6'b100000) begin bad++; $display("FAIL wr_ready got=%b want=100000", rdy_v); end
    total++; if (wen_v !== 6'b110101) begin bad++; $display("FAIL wr_we_n got=%b want=110101", wen_v); end
    total++; if (oe_v !== 6'b011110) begin bad++; $display("FAIL wr_oe got=%b want=011110", oe_v); end
    total++; if (mem[0] !== 16'h5678) begin bad++; $display("FAIL wr_mem0 got=%h want=5678", mem[0]); end
    total++; if (mem[1] !== 16'h1234) begin bad++; $display("FAIL wr_mem1 got=%h want=1234", mem[1]); end
  endtask

  task automatic test_read;
    run_req(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    total++; if (rd_r[5] !== 32'h1234_5678) begin bad++; $display("FAIL rd_data got=%h want=12345678", rd_r[5]); end
    total++; if (oe_v !== 6'b000000) begin bad++; $display("FAIL rd_oe got=%b want=000000", oe_v); end
    total++; if (wen_v !== 6'b111111) begin bad++; $display("FAIL rd_we_n got=%b want=111111", wen_v); end
    total++; if (rdy_v !== 6'b100000) begin bad++; $display("FAIL rd_ready got=%b want=100000", rdy_v); end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp_a [4] = '{18'd2, 18'd2, 18'd3, 18'd3};
    run_req(1'b1, 1'b0, 32'd1028, 32'hCAFE_BABE, 1'b0);
    for (int i = 1; i < 5; i++) begin
      total++;
      if (addr_r[i] !== exp_a[i-1]) begin
        bad++; $display("FAIL b2b_wr_addr cyc=%0d got=%h want=%h", i, addr_r[i], exp_a[i-1]);
      end
    end
    run_req(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      total++;
      if (addr_r[i] !== exp_a[i-1]) begin
        bad++; $display("FAIL b2b_rd_addr cyc=%0d got=%h want=%h", i, addr_r[i], exp_a[i-1]);
      end
    end
    total++; if (rdy_v !== 6'b100000) begin bad++; $display("FAIL b2b_ready got=%b want=100000", rdy_v); end
    total++; if (rd_r[5] !== 32'hCAFE_BABE) begin bad++; $display("FAIL b2b_data got=%h want=cafebabe", rd_r[5]); end
  endtask

  task automatic test_both_requests;
    run_req(1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, 1'b0);
    total++; if (mem[4] !== 16'h0F0F) begin bad++; $display("FAIL both_mem4 got=%h want=0f0f", mem[4]); end
    total++; if (mem[5] !== 16'hA5A5) begin bad++; $display("FAIL both_mem5 got=%h want=a5a5", mem[5]); end
    total++; if (wen_v !== 6'b110101) begin bad++; $display("FAIL both_we_n got=%b want=110101", wen_v); end
    total++; if (rd_r[5] !== 32'hCAFE_BABE) begin bad++; $display("FAIL both_rdata got=%h want=cafebabe", rd_r[5]); end
  endtask

  task automatic test_drop_wrap;
    logic [17:0] exp_a [4] = '{18'h3FFFE, 18'h3FFFE, 18'h3FFFF, 18'h3FFFF};
    run_req(1'b1, 1'b0, 32'd1020, 32'h1111_2222, 1'b1);
    for (int i = 1; i < 5; i++) begin
      total++;
      if (addr_r[i] !== exp_a[i-1]) begin
        bad++; $display("FAIL wrap_addr cyc=%0d got=%h want=%h", i, addr_r[i], exp_a[i-1]);
      end
    end
    total++; if (rdy_v !== 6'b100000) begin bad++; $display("FAIL drop_ready got=%b want=100000", rdy_v); end
    total++; if (mem[18'h3FFFE] !== 16'h2222) begin bad++; $display("FAIL wrap_lo got=%h want=2222", mem[18'h3FFFE]); end
    total++; if (mem[18'h3FFFF] !== 16'h1111) begin bad++; $display("FAIL wrap_hi got=%h want=1111", mem[18'h3FFFF]); end
  endtask

  task automatic test_reset_mid_write;
    mem[6] = 16'h0000;
    mem[7] = 16'hDEAD;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'hBEEF_1234;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd7) begin
      bad++; $display("FAIL mid_phase we_n=%b addr=%h want we_n=0 addr=7", sram_we_n, sram_addr);
    end
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rstmid_we_n got=%b want=1", sram_we_n); end
    total++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got=%b want=0", sram_dq_oe); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h want=0", read_data); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", ready); end
    total++; if (mem[6] !== 16'h1234) begin bad++; $display("FAIL rstmid_lo got=%h want=1234", mem[6]); end
    total++; if (mem[7] !== 16'hDEAD) begin bad++; $display("FAIL rstmid_hi got=%h want=dead", mem[7]); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_requests();
    test_drop_wrap();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
